// File: rtl/local_bias_buf.sv
// local_bias_buf: parametrised bias store for the convolution/FC datapath.
// The load side takes a streaming burst (base, length, then valid/ready beats).
// The read side returns LANES consecutive entries one cycle after each request.
// Entries or lanes that fall outside DEPTH are never written and read back as
// zero. Either case sets a sticky error flag that only rst clears.
module local_bias_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int LANES  = 2,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic [ADDR_W-1:0]       load_base,
  input  logic [ADDR_W-1:0]       load_len,
  input  logic                    wr_valid,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  output logic                    load_done,
  output logic                    busy,
  input  logic                    clear,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic                    err_oob
);

  // Read base index width: wide enough that LANES*rd_addr never truncates.
  localparam int LGL  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW   = ADDR_W + LGL;
  localparam int MA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [ADDR_W-1:0]       ptr_q, ptr_d;
  logic [ADDR_W-1:0]       rem_q, rem_d;
  // ptr_ovf_q remembers that ptr stepped past all-ones.
  // Later beats then stay out of range instead of wrapping back onto entry 0.
  logic                    ptr_ovf_q, ptr_ovf_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    wr_oob;
  logic                    wr_en;
  logic                    wr_oob_hit;
  logic                    clr_en;

  logic [BW-1:0]           rd_base;
  logic [LANES*DATA_W-1:0] rd_data_d;
  logic                    rd_oob;
  logic                    rd_valid_q;
  logic [LANES*DATA_W-1:0] rd_data_q;
  logic                    err_oob_q;

  assign wr_oob = ptr_ovf_q | (64'(ptr_q) >= 64'(DEPTH));

  // Burst FSM next-state: capture the burst, count accepted beats, and steer writes and clear.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    ptr_ovf_d  = ptr_ovf_q;
    clr_en     = 1'b0;
    wr_en      = 1'b0;
    wr_oob_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          if (load_len != '0) begin
            state_d   = S_LOAD;
            ptr_d     = load_base;
            rem_d     = load_len;
            ptr_ovf_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end else if (clear) begin
          clr_en = 1'b1;
        end
      end
      S_LOAD: begin
        if (wr_valid) begin
          if (wr_oob) wr_oob_hit = 1'b1;
          else        wr_en      = 1'b1;
          ptr_d     = ptr_q + ADDR_W'(1);
          ptr_ovf_d = ptr_ovf_q | (&ptr_q);
          rem_d     = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers for the burst FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      ptr_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      ptr_ovf_q <= ptr_ovf_d;
    end
  end

  // Bias storage: the whole array is zeroed on reset or clear; otherwise it takes one burst write per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_en) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[ptr_q[MA_W-1:0]] <= wr_data;
    end
  end

  assign rd_base = BW'(rd_addr) * BW'(LANES);

  // Read lane gather from the current (pre-write, pre-clear) array contents; out-of-range lanes read zero.
  always_comb begin
    logic [BW-1:0] idx;
    idx       = '0;
    rd_data_d = '0;
    rd_oob    = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      idx = rd_base + BW'(k);
      if (64'(idx) >= 64'(DEPTH)) rd_oob = 1'b1;
      else rd_data_d[k*DATA_W +: DATA_W] = mem_q[idx[MA_W-1:0]];
    end
  end

  // Registered read port. The sticky error flag accumulates out-of-range writes and reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= rd_data_d;
      err_oob_q  <= err_oob_q | wr_oob_hit | (rd_req & rd_oob);
    end
  end

  assign wr_ready  = (state_q == S_LOAD);
  assign load_done = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_local_bias_buf.sv
// Directed testbench for local_bias_buf with default parameters (16-bit entries, 64 deep, 2 lanes).
module tb_local_bias_buf;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int LANES  = 2;
  localparam int ADDR_W = 16;

  logic                    clk;
  logic                    rst;
  logic                    load_start;
  logic [ADDR_W-1:0]       load_base;
  logic [ADDR_W-1:0]       load_len;
  logic                    wr_valid;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_ready;
  logic                    load_done;
  logic                    busy;
  logic                    clear;
  logic                    rd_req;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_valid;
  logic [LANES*DATA_W-1:0] rd_data;
  logic                    err_oob;

  int tests;
  int fails;

  local_bias_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .load_done(load_done), .busy(busy), .clear(clear),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .err_oob(err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all are entered and left on a falling edge.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic v, output logic [31:0] d);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    v = rd_valid; d = rd_data;
    rd_req = 1'b0;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    load_start = 1'b1; load_base = b; load_len = n;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [DATA_W-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic v; logic [31:0] d;
    tests++;
    if ({wr_ready, load_done, busy, rd_valid, err_oob} !== 5'b0 || rd_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got ctl=%b data=%h, want ctl=00000 data=0",
               {wr_ready, load_done, busy, rd_valid, err_oob}, rd_data);
    end
    for (int a = 0; a < DEPTH/LANES; a++) begin
      do_read(ADDR_W'(a), v, d);
      tests++;
      if (v !== 1'b1 || d !== 32'h0) begin
        fails++;
        $display("FAIL reset_read[%0d]: got v=%b d=%h, want v=1 d=0", a, v, d);
      end
    end
    tests++;
    if (err_oob !== 1'b0) begin
      fails++; $display("FAIL reset_err: got %b, want 0", err_oob);
    end
  endtask

  task automatic test_load_basic;
    logic v; logic [31:0] d;
    start_load(16'd4, 16'd3);
    tests++;
    if (busy !== 1'b1 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL basic_enter_load: got busy=%b rdy=%b, want 1 1", busy, wr_ready);
    end
    beat(16'h0011);
    beat(16'h0022);
    @(negedge clk);
    tests++;
    if (load_done !== 1'b0 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL basic_stall: got done=%b rdy=%b, want 0 1", load_done, wr_ready);
    end
    beat(16'h0033);
    tests++;
    if (load_done !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b0) begin
      fails++; $display("FAIL basic_done: got done=%b busy=%b rdy=%b, want 1 1 0", load_done, busy, wr_ready);
    end
    @(negedge clk);
    tests++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL basic_idle: got done=%b busy=%b, want 0 0", load_done, busy);
    end
    do_read(16'd2, v, d);
    tests++;
    if (v !== 1'b1 || d !== 32'h0022_0011) begin
      fails++; $display("FAIL basic_rd2: got v=%b d=%h, want v=1 d=00220011", v, d);
    end
    do_read(16'd3, v, d);
    tests++;
    if (d !== 32'h0000_0033 || err_oob !== 1'b0) begin
      fails++; $display("FAIL basic_rd3: got d=%h err=%b, want d=00000033 err=0", d, err_oob);
    end
  endtask

  task automatic test_oob_burst;
    logic v; logic [31:0] d;
    start_load(16'(DEPTH-1), 16'd2);
    beat(16'hAAAA);
    tests++;
    if (err_oob !== 1'b0) begin
      fails++; $display("FAIL oob_last_entry: got err=%b, want 0", err_oob);
    end
    beat(16'hBBBB);
    tests++;
    if (load_done !== 1'b1 || err_oob !== 1'b1) begin
      fails++; $display("FAIL oob_done: got done=%b err=%b, want 1 1", load_done, err_oob);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL oob_busy: got %b, want 0", busy);
    end
    do_read(16'(DEPTH/LANES-1), v, d);
    tests++;
    if (d !== 32'hAAAA_0000) begin
      fails++; $display("FAIL oob_rd31: got %h, want aaaa0000", d);
    end
  endtask

  task automatic test_collision;
    logic v; logic [31:0] d;
    start_load(16'd10, 16'd2);
    wr_valid = 1'b1; wr_data = 16'h0C0C; rd_req = 1'b1; rd_addr = 16'd5;
    @(negedge clk);
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      fails++; $display("FAIL coll_old: got v=%b d=%h, want v=1 d=0", rd_valid, rd_data);
    end
    wr_data = 16'h0D0D;
    load_start = 1'b1; load_base = 16'd0; load_len = 16'd5;
    @(negedge clk);
    tests++;
    if (rd_data !== 32'h0000_0C0C || load_done !== 1'b1) begin
      fails++; $display("FAIL coll_next: got d=%h done=%b, want d=00000c0c done=1", rd_data, load_done);
    end
    wr_valid = 1'b0; rd_req = 1'b0; load_start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL coll_start_ignored: got busy=%b, want 0", busy);
    end
    do_read(16'd5, v, d);
    tests++;
    if (d !== 32'h0D0D_0C0C) begin
      fails++; $display("FAIL coll_after: got %h, want 0d0d0c0c", d);
    end
  endtask

  task automatic test_clear;
    logic v; logic [31:0] d;
    start_load(16'd20, 16'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if (busy !== 1'b1 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL clr_in_load_state: got busy=%b rdy=%b, want 1 1", busy, wr_ready);
    end
    beat(16'h5555);
    @(negedge clk);
    do_read(16'd2, v, d);
    tests++;
    if (d !== 32'h0022_0011) begin
      fails++; $display("FAIL clr_in_load_ignored: got %h, want 00220011", d);
    end
    do_read(16'd10, v, d);
    tests++;
    if (d !== 32'h0000_5555) begin
      fails++; $display("FAIL clr_load_data: got %h, want 00005555", d);
    end
    clear = 1'b1; rd_req = 1'b1; rd_addr = 16'd2;
    @(negedge clk);
    clear = 1'b0; rd_req = 1'b0;
    tests++;
    if (rd_data !== 32'h0022_0011) begin
      fails++; $display("FAIL clr_read_same_cycle: got %h, want 00220011", rd_data);
    end
    do_read(16'd2, v, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL clr_rd2: got %h, want 0", d);
    end
    do_read(16'd10, v, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL clr_rd10: got %h, want 0", d);
    end
    do_read(16'd31, v, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL clr_rd31: got %h, want 0", d);
    end
    clear = 1'b1;
    start_load(16'd0, 16'd1);
    clear = 1'b0;
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++; $display("FAIL clr_start_wins: got rdy=%b, want 1", wr_ready);
    end
    beat(16'h4242);
    @(negedge clk);
    do_read(16'd0, v, d);
    tests++;
    if (d !== 32'h0000_4242) begin
      fails++; $display("FAIL clr_start_data: got %h, want 00004242", d);
    end
  endtask

  task automatic test_len0;
    start_load(16'd7, 16'd0);
    tests++;
    if (load_done !== 1'b1 || busy !== 1'b1 || wr_ready !== 1'b0) begin
      fails++; $display("FAIL len0_done: got done=%b busy=%b rdy=%b, want 1 1 0", load_done, busy, wr_ready);
    end
    @(negedge clk);
    tests++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL len0_idle: got done=%b busy=%b, want 0 0", load_done, busy);
    end
  endtask

  task automatic test_rst_mid;
    logic v; logic [31:0] d;
    int seen;
    start_load(16'd0, 16'd8);
    beat(16'h0101);
    beat(16'h0202);
    wr_valid = 1'b1; wr_data = 16'h0303; rd_req = 1'b1; rd_addr = 16'd0;
    @(negedge clk);
    wr_valid = 1'b0; rd_req = 1'b0;
    tests++;
    if (rd_data !== 32'h0202_0101 || err_oob !== 1'b1) begin
      fails++; $display("FAIL rst_pre: got d=%h err=%b, want 02020101 1", rd_data, err_oob);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({wr_ready, load_done, busy, rd_valid, err_oob} !== 5'b0 || rd_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_async: got ctl=%b data=%h, want ctl=00000 data=0",
               {wr_ready, load_done, busy, rd_valid, err_oob}, rd_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (load_done !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL rst_no_done: got %0d pulses, want 0", seen);
    end
    do_read(16'd0, v, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL rst_mem0: got %h, want 0", d);
    end
    start_load(16'd0, 16'd2);
    beat(16'h7777);
    beat(16'h8888);
    tests++;
    if (load_done !== 1'b1) begin
      fails++; $display("FAIL rst_fresh_done: got %b, want 1", load_done);
    end
    @(negedge clk);
    do_read(16'd0, v, d);
    tests++;
    if (d !== 32'h8888_7777 || err_oob !== 1'b0) begin
      fails++; $display("FAIL rst_fresh_data: got d=%h err=%b, want 88887777 0", d, err_oob);
    end
  endtask

  task automatic test_boundary_reads;
    logic v; logic [31:0] d;
    do_read(16'h8000, v, d);
    tests++;
    if (v !== 1'b1 || d !== 32'h0 || err_oob !== 1'b1) begin
      fails++; $display("FAIL rd_no_trunc: got v=%b d=%h err=%b, want 1 0 1", v, d, err_oob);
    end
    do_read(16'd32, v, d);
    tests++;
    if (d !== 32'h0) begin
      fails++; $display("FAIL rd_oob32: got %h, want 0", d);
    end
    start_load(16'hFFFF, 16'd2);
    beat(16'h1234);
    beat(16'h5678);
    tests++;
    if (load_done !== 1'b1) begin
      fails++; $display("FAIL ptr_ovf_done: got %b, want 1", load_done);
    end
    @(negedge clk);
    do_read(16'd0, v, d);
    tests++;
    if (d !== 32'h8888_7777) begin
      fails++; $display("FAIL ptr_ovf_nowrap: got %h, want 88887777", d);
    end
  endtask

  task automatic test_back_to_back;
    rd_req = 1'b1; rd_addr = 16'd2;
    @(negedge clk);
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
      fails++; $display("FAIL b2b_first: got v=%b d=%h, want 1 0", rd_valid, rd_data);
    end
    rd_addr = 16'd0;
    @(negedge clk);
    tests++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h8888_7777) begin
      fails++; $display("FAIL b2b_second: got v=%b d=%h, want 1 88887777", rd_valid, rd_data);
    end
    rd_req = 1'b0; rd_addr = 16'd1;
    @(negedge clk);
    tests++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h8888_7777) begin
      fails++; $display("FAIL b2b_hold: got v=%b d=%h, want 0 88887777", rd_valid, rd_data);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    wr_valid = 1'b0; wr_data = '0; clear = 1'b0; rd_req = 1'b0; rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_load_basic;
    test_oob_burst;
    test_collision;
    test_clear;
    test_len0;
    test_rst_mid;
    test_boundary_reads;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
